fx_mem_resp: RTL

//  Memory-side responder for the machine's CPU ROM and RAM ports. It samples each bus

---
 rtl/fx_mem_resp.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fx_mem_resp.sv
// CPU ROM/RAM bus responder: turns each CPU bus cycle into one request on a 32-bit
// memory port and returns read data plus a one-CE READYn pulse to the CPU.
module fx_mem_resp #(
  parameter int                MEM_AW   = 24,
  parameter logic [MEM_AW-1:0] ROM_BASE = MEM_AW'(24'h200000),
  parameter int                MIN_WAIT = 1
) (
  input  logic              CLK,
  input  logic              RESn,
  input  logic              CE,
  input  logic              BCYSTn,
  input  logic [19:0]       ROM_A,
  input  logic              ROM_CEn,
  output logic [15:0]       ROM_DO,
  output logic              ROM_READYn,
  input  logic [20:0]       RAM_A,
  input  logic [31:0]       RAM_DI,
  input  logic              RAM_CEn,
  input  logic              RAM_WEn,
  input  logic [3:0]        RAM_BEn,
  output logic [31:0]       RAM_DO,
  output logic              RAM_READYn,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  input  logic              MEM_ACK
);

  localparam int WW = (MIN_WAIT > 1) ? $clog2(MIN_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(MIN_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [MEM_AW-1:0] mem_addr_reg, mem_addr_next;
  logic              mem_rd_reg, mem_rd_next;
  logic              mem_wr_reg, mem_wr_next;
  logic [3:0]        mem_be_reg, mem_be_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic [15:0]       rom_do_reg, rom_do_next;
  logic [31:0]       ram_do_reg, ram_do_next;
  logic              rom_ready_n_reg, rom_ready_n_next;
  logic              ram_ready_n_reg, ram_ready_n_next;
  logic              rom_sel_reg, rom_sel_next;
  logic              half_reg, half_next;
  logic [WW-1:0]     wait_reg, wait_next;
  logic              accept;

  // Address bits below the 32-bit word are implied by the half-select / byte enables.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ROM_A[0], RAM_A[1:0]};

  // A new bus cycle may start from IDLE or on the closing CE of DONE.
  assign accept = CE && !BCYSTn && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next       = state_reg;
    mem_addr_next    = mem_addr_reg;
    mem_rd_next      = mem_rd_reg;
    mem_wr_next      = mem_wr_reg;
    mem_be_next      = mem_be_reg;
    mem_wdata_next   = mem_wdata_reg;
    rom_do_next      = rom_do_reg;
    ram_do_next      = ram_do_reg;
    rom_ready_n_next = rom_ready_n_reg;
    ram_ready_n_next = ram_ready_n_reg;
    rom_sel_next     = rom_sel_reg;
    half_next        = half_reg;
    wait_next        = wait_reg;

    if (CE && (wait_reg != '0)) begin
      wait_next = wait_reg - 1'b1;
    end

    case (state_reg)
      REQ: begin
        // MEM_ACK is a raw one-CLK pulse, so it is taken regardless of CE.
        if (MEM_ACK) begin
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          if (mem_rd_reg) begin
            if (rom_sel_reg) begin
              rom_do_next = half_reg ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
            end else begin
              ram_do_next = MEM_RDATA;
            end
          end
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (CE && (wait_reg == '0)) begin
          if (rom_sel_reg) begin
            rom_ready_n_next = 1'b0;
          end else begin
            ram_ready_n_next = 1'b0;
          end
          state_next = DONE;
        end
      end
      DONE: begin
        if (CE) begin
          rom_ready_n_next = 1'b1;
          ram_ready_n_next = 1'b1;
          state_next       = IDLE;
        end
      end
      default: begin
      end
    endcase

    if (accept) begin
      if (!ROM_CEn) begin
        mem_addr_next = ROM_BASE + MEM_AW'({ROM_A[19:2], 2'b00});
        half_next     = ROM_A[1];
        rom_sel_next  = 1'b1;
        mem_rd_next   = 1'b1;
        wait_next     = WAIT_INIT;
        state_next    = REQ;
      end else if (!RAM_CEn) begin
        rom_sel_next = 1'b0;
        wait_next    = WAIT_INIT;
        if (RAM_WEn) begin
          mem_addr_next = MEM_AW'({RAM_A[20:2], 2'b00});
          mem_rd_next   = 1'b1;
          state_next    = REQ;
        end else if (RAM_BEn != 4'hF) begin
          mem_addr_next  = MEM_AW'({RAM_A[20:2], 2'b00});
          mem_wr_next    = 1'b1;
          mem_be_next    = ~RAM_BEn;
          mem_wdata_next = RAM_DI;
          state_next     = REQ;
        end else begin
          // Write with no lanes enabled: nothing to send, just pace the handshake.
          state_next = HOLD;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_reg       <= IDLE;
      mem_addr_reg    <= '0;
      mem_rd_reg      <= 1'b0;
      mem_wr_reg      <= 1'b0;
      mem_be_reg      <= '0;
      mem_wdata_reg   <= '0;
      rom_do_reg      <= '0;
      ram_do_reg      <= '0;
      rom_ready_n_reg <= 1'b1;
      ram_ready_n_reg <= 1'b1;
      rom_sel_reg     <= 1'b0;
      half_reg        <= 1'b0;
      wait_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      mem_addr_reg    <= mem_addr_next;
      mem_rd_reg      <= mem_rd_next;
      mem_wr_reg      <= mem_wr_next;
      mem_be_reg      <= mem_be_next;
      mem_wdata_reg   <= mem_wdata_next;
      rom_do_reg      <= rom_do_next;
      ram_do_reg      <= ram_do_next;
      rom_ready_n_reg <= rom_ready_n_next;
      ram_ready_n_reg <= ram_ready_n_next;
      rom_sel_reg     <= rom_sel_next;
      half_reg        <= half_next;
      wait_reg        <= wait_next;
    end
  end

  assign MEM_ADDR   = mem_addr_reg;
  assign MEM_RD     = mem_rd_reg;
  assign MEM_WR     = mem_wr_reg;
  assign MEM_BE     = mem_be_reg;
  assign MEM_WDATA  = mem_wdata_reg;
  assign ROM_DO     = rom_do_reg;
  assign RAM_DO     = ram_do_reg;
  assign ROM_READYn = rom_ready_n_reg;
  assign RAM_READYn = ram_ready_n_reg;

endmodule
